spi_memory_fsm: RTL and testbench
=================================

SPI_MEMORY_FSM -- requirements
Module: spi_memory_fsm

Interface
REQ-001 Parameter addrwidth, default 7, memory address width in bits.
REQ-002 Parameter width, default 8, data word and shift-register width in bits.
REQ-003 clk  input  1  FPGA system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 cs  input  1  conditioned chip select, active low.
REQ-006 sclkEdge  input  1  one-clk strobe on each serial-clock edge that advances the shift register.
REQ-007 shiftRegOut  input  width  shift-register parallel output.
REQ-008 memDataOut  output  width  mem[addrReg], combinational read; feeds shift-register parallel input.
REQ-009 srLoad  output  1  one-clk parallel-load strobe to the shift register.
REQ-010 misoBufe  output  1  MISO tristate buffer enable, high while sending read data.
REQ-011 dmWe  output  1  one-clk data-memory write strobe, observable.
REQ-012 addr  output  addrwidth  latched address register addrReg.
REQ-013 state  output  3  current state encoding, for LEDs and debug.

Function
REQ-014 The block SHALL contain a 2^addrwidth x width memory, a 4-bit bit counter, addrReg and a state register.
REQ-015 State encoding SHALL be: IDLE=0, GET_ADDR=1, GOT_ADDR=2, READ_LOAD=3, READ_SEND=4, WRITE_RECV=5, WRITE_MEM=6, DONE=7.
REQ-016 IDLE: counter=0. If cs==0, next state is GET_ADDR.
REQ-017 GET_ADDR: each sclkEdge increments the counter. When sclkEdge arrives with counter==7, the next state is GOT_ADDR and the counter clears.
REQ-018 GOT_ADDR lasts one cycle. addrReg<=shiftRegOut[width-1:1]. If shiftRegOut[0]==1 the next state is READ_LOAD, else WRITE_RECV.
REQ-019 READ_LOAD lasts one cycle. srLoad=1 with memDataOut=mem[addrReg]. The next state is READ_SEND.
REQ-020 READ_SEND: misoBufe=1. It counts 8 sclkEdge strobes, then goes to DONE.
REQ-021 WRITE_RECV: counts 8 sclkEdge strobes, then goes to WRITE_MEM.
REQ-022 WRITE_MEM lasts one cycle. dmWe=1 and mem[addrReg]<=shiftRegOut. The next state is DONE.
REQ-023 DONE: all strobes are low and further sclkEdge strobes are ignored. The block waits for cs==1.
REQ-024 srLoad, dmWe and misoBufe SHALL be Moore outputs decoded from state only. All other states drive them 0.
REQ-025 cs==1 in any non-IDLE state SHALL force the next state to IDLE and clear the counter. This takes priority over all transitions.
REQ-026 cs==1 in WRITE_MEM SHALL suppress the memory write; dmWe remains asserted by decode, but mem is unchanged.
REQ-027 sclkEdge during GOT_ADDR, READ_LOAD or WRITE_MEM SHALL be ignored and not counted.
REQ-028 The counter SHALL never exceed 8 and SHALL clear on every state change.
REQ-029 Latency from the 8th address sclkEdge to srLoad SHALL be exactly 2 clk cycles, and to the first cycle of misoBufe exactly 3 cycles.

Reset
REQ-030 When reset==1 at a rising clk, state<=IDLE, counter<=0 and addrReg<=0. srLoad, dmWe and misoBufe read 0 the following cycle.
REQ-031 Reset SHALL take priority over cs and sclkEdge, including mid-transaction.
REQ-032 Memory contents SHALL NOT be affected by reset.

Verification
REQ-033 Reset: assert reset for 2 cycles from power-up -> state=0, addr=0, srLoad=dmWe=misoBufe=0.
REQ-034 Write: cs=0, 8 sclkEdge strobes with shiftRegOut=0x54 at the 8th, then 8 strobes with shiftRegOut=0xC3 at the 8th -> addr=0x2A, dmWe high exactly 1 cycle, mem[0x2A]=0xC3, state=7.
REQ-035 Read back: cs=1 then 0, 8 strobes with shiftRegOut=0x55 -> srLoad high 1 cycle, 2 cycles after the 8th strobe, with memDataOut=0xC3. misoBufe is high from the next cycle until the 8th strobe, then state=7 and misoBufe=0.
REQ-036 Abort: write to 0x10 with cs raised after 5 data strobes -> state=0 next cycle, dmWe never asserted, mem[0x10] unchanged.
REQ-037 Reset mid-read: pulse reset during READ_SEND -> state=0 and misoBufe=0 next cycle. A following read of 0x2A still returns 0xC3.
REQ-038 DONE hold: keep cs=0 and issue 10 extra strobes in DONE -> state stays 7, no strobes, counter not advanced.

Source files
------------

// File: rtl/spi_memory_fsm.sv
// SPI slave memory controller. It takes an address/RW byte from the shift register.
// A read loads the addressed word for MISO; a write stores the next received byte.
module spi_memory_fsm #(
  parameter int addrwidth = 7,
  parameter int width     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 sclkEdge,
  input  logic [width-1:0]     shiftRegOut,
  output logic [width-1:0]     memDataOut,
  output logic                 srLoad,
  output logic                 misoBufe,
  output logic                 dmWe,
  output logic [addrwidth-1:0] addr,
  output logic [2:0]           state
);

  localparam int DEPTH = 1 << addrwidth;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] GET_ADDR   = 3'd1;
  localparam logic [2:0] GOT_ADDR   = 3'd2;
  localparam logic [2:0] READ_LOAD  = 3'd3;
  localparam logic [2:0] READ_SEND  = 3'd4;
  localparam logic [2:0] WRITE_RECV = 3'd5;
  localparam logic [2:0] WRITE_MEM  = 3'd6;
  localparam logic [2:0] DONE       = 3'd7;

  logic [2:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [addrwidth-1:0] addr_q, addr_d;
  logic [width-1:0]     mem_q [DEPTH];
  logic [width-2:0]     addr_field;
  logic                 mem_we;

  // Top bits of the command byte are the address; bit 0 selects read (1) or write (0).
  assign addr_field = shiftRegOut[width-1:1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    if ((state_q != IDLE) && cs) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (!cs) state_d = GET_ADDR;
        end
        GET_ADDR, READ_SEND, WRITE_RECV: begin
          if (sclkEdge) begin
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              case (state_q)
                GET_ADDR:  state_d = GOT_ADDR;
                READ_SEND: state_d = DONE;
                default:   state_d = WRITE_MEM;
              endcase
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        GOT_ADDR: begin
          addr_d  = addrwidth'(addr_field);
          cnt_d   = '0;
          state_d = shiftRegOut[0] ? READ_LOAD : WRITE_RECV;
        end
        READ_LOAD: begin
          cnt_d   = '0;
          state_d = READ_SEND;
        end
        WRITE_MEM: begin
          cnt_d   = '0;
          state_d = DONE;
        end
        DONE: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // A chip-select release during WRITE_MEM aborts the store even though dmWe is decoded high.
  assign mem_we = (state_q == WRITE_MEM) && !cs;

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q] <= shiftRegOut;
  end

  assign memDataOut = mem_q[addr_q];
  assign srLoad     = (state_q == READ_LOAD);
  assign misoBufe   = (state_q == READ_SEND);
  assign dmWe       = (state_q == WRITE_MEM);
  assign addr       = addr_q;
  assign state      = state_q;

endmodule

// File: tb/tb_spi_memory_fsm.sv
// Bench for spi_memory_fsm. A transaction-level memory model feeds a scoreboard of
// expected srLoad/dmWe events, and an independent monitor pops and checks them.
module tb_spi_memory_fsm;

  localparam int AW = 7;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset, cs, sclkEdge;
  logic [DW-1:0] shiftRegOut;
  logic [DW-1:0] memDataOut;
  logic          srLoad, misoBufe, dmWe;
  logic [AW-1:0] addr;
  logic [2:0]    state;

  always #5 clk = ~clk;

  spi_memory_fsm #(.addrwidth(AW), .width(DW)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclkEdge(sclkEdge),
    .shiftRegOut(shiftRegOut), .memDataOut(memDataOut), .srLoad(srLoad),
    .misoBufe(misoBufe), .dmWe(dmWe), .addr(addr), .state(state)
  );

  typedef struct {
    bit            is_read;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ev_t;

  ev_t           sb_q[$];
  ev_t           mon_e;
  logic [DW-1:0] ref_mem [1<<AW];
  bit            ref_valid [1<<AW];
  logic [AW-1:0] wr_addrs[$];
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every srLoad or dmWe cycle must match the next expected event.
  always @(negedge clk) begin
    if (srLoad || dmWe) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_strobe", 32'({srLoad, dmWe}), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_kind", 32'(srLoad), 32'(mon_e.is_read));
        chk("sb_addr", 32'(addr), 32'(mon_e.a));
        if (mon_e.is_read) chk("sb_rdata", 32'(memDataOut), 32'(mon_e.d));
        else chk("sb_wstate", 32'(state), 32'd6);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap();
    int n = $urandom_range(0, 2);
    repeat (n) tick();
  endtask

  task automatic strobes(input int n, input logic [DW-1:0] last);
    for (int i = 0; i < n; i++) begin
      idle_gap();
      sclkEdge    = 1'b1;
      shiftRegOut = (i == n - 1) ? last : DW'($urandom);
      tick();
      sclkEdge = 1'b0;
    end
  endtask

  task automatic begin_txn(input logic [DW-1:0] cmd);
    cs = 1'b0;
    tick();
    chk("enter_get_addr", 32'(state), 32'd1);
    strobes(8, cmd);
    chk("got_addr", 32'(state), 32'd2);
  endtask

  task automatic end_txn();
    cs = 1'b1;
    tick();
    chk("idle_after_cs", 32'(state), 32'd0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit kill_in_wmem);
    sb_q.push_back('{1'b0, a, d});
    begin_txn({a, 1'b0});
    sclkEdge = 1'($urandom);
    tick();
    sclkEdge = 1'b0;
    chk("write_recv", 32'(state), 32'd5);
    chk("addr_latched", 32'(addr), 32'(a));
    strobes(8, d);
    chk("write_mem", 32'(state), 32'd6);
    if (kill_in_wmem) begin
      cs = 1'b1;
      tick();
      chk("wmem_abort_idle", 32'(state), 32'd0);
      chk("wmem_abort_dmwe", 32'(dmWe), 32'd0);
      if (ref_valid[a]) chk("wmem_abort_mem", 32'(memDataOut), 32'(ref_mem[a]));
    end else begin
      ref_mem[a]   = d;
      ref_valid[a] = 1'b1;
      wr_addrs.push_back(a);
      tick();
      chk("write_done", 32'(state), 32'd7);
      chk("dmwe_one_cycle", 32'(dmWe), 32'd0);
      chk("mem_written", 32'(memDataOut), 32'(d));
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int reset_after);
    sb_q.push_back('{1'b1, a, ref_mem[a]});
    begin_txn({a, 1'b1});
    chk("rd_lat1_srload", 32'(srLoad), 32'd0);
    tick();
    chk("rd_lat2_srload", 32'(srLoad), 32'd1);
    chk("rd_lat2_bufe", 32'(misoBufe), 32'd0);
    sclkEdge = 1'($urandom);
    tick();
    sclkEdge = 1'b0;
    chk("rd_lat3_srload", 32'(srLoad), 32'd0);
    chk("rd_lat3_bufe", 32'(misoBufe), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == reset_after) begin
        reset = 1'b1;
        cs    = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_state", 32'(state), 32'd0);
        chk("rst_mid_bufe", 32'(misoBufe), 32'd0);
        chk("rst_mid_addr", 32'(addr), 32'd0);
        return;
      end
      idle_gap();
      chk("bufe_hold", 32'(misoBufe), 32'd1);
      sclkEdge    = 1'b1;
      shiftRegOut = DW'($urandom);
      tick();
      sclkEdge = 1'b0;
    end
    chk("read_done", 32'(state), 32'd7);
    chk("bufe_off", 32'(misoBufe), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] ra;
    reset = 1'b1; cs = 1'b1; sclkEdge = 1'b0; shiftRegOut = '0;
    tick();
    tick();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_addr", 32'(addr), 32'd0);
    chk("reset_srload", 32'(srLoad), 32'd0);
    chk("reset_dmwe", 32'(dmWe), 32'd0);
    chk("reset_bufe", 32'(misoBufe), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_hold", 32'(state), 32'd0);

    do_write(7'h2A, 8'hC3, 1'b0);
    end_txn();
    do_read(7'h2A, -1);
    end_txn();

    do_write(7'h10, 8'h5A, 1'b0);
    end_txn();
    begin_txn({7'h10, 1'b0});
    tick();
    chk("abort_recv", 32'(state), 32'd5);
    strobes(5, 8'hEE);
    cs = 1'b1;
    tick();
    chk("abort_idle", 32'(state), 32'd0);
    chk("abort_mem", 32'(memDataOut), 32'(ref_mem[7'h10]));
    do_read(7'h10, -1);
    end_txn();

    do_write(7'h10, 8'h77, 1'b1);
    do_read(7'h10, -1);
    end_txn();

    do_read(7'h2A, 3);
    end_txn();
    do_read(7'h2A, -1);
    end_txn();

    do_write(7'h05, 8'h3C, 1'b0);
    for (int i = 0; i < 10; i++) begin
      idle_gap();
      sclkEdge = 1'b1;
      tick();
      sclkEdge = 1'b0;
      chk("done_hold_state", 32'(state), 32'd7);
      chk("done_no_strobes", 32'({srLoad, dmWe, misoBufe}), 32'd0);
    end
    end_txn();
    do_read(7'h05, -1);
    end_txn();

    repeat (30) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write(AW'($urandom), DW'($urandom), 1'b0);
      end else begin
        ra = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
        do_read(ra, -1);
      end
      end_txn();
    end

    repeat (3) tick();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
